// File: rtl/imem_boot_loader_if.sv
// Boot-loader bus bundle: load request, program byte stream, instruction-memory
// write port and core status. The host drives through master; the loader
// implements slave.
interface imem_boot_loader_if #(
    parameter int unsigned LEN_W = 16
) ();
    // Load request
    logic             start;
    logic [LEN_W-1:0] len;

    // Program byte stream
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_ready;

    // Instruction memory byte-write port
    logic             wr_en;
    logic [63:0]      wr_addr;
    logic [7:0]       wr_data;

    // Core control and status
    logic             cpu_hold;
    logic             busy;
    logic             done;
    logic             error;

    modport master (
        output start, len, in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data, cpu_hold, busy, done, error
    );

    modport slave (
        input  start, len, in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data, cpu_hold, busy, done, error
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Instruction-memory boot loader. Streams len program bytes into memory from
// address 0, then checks one trailing checksum byte (bytes + checksum must sum
// to 0 mod 256). The core is held until a load finishes with a good checksum.
module imem_boot_loader #(
    parameter int unsigned MEM_BYTES = 96,
    parameter int unsigned LEN_W     = 16
) (
    input logic               clk,
    input logic               reset,
    imem_boot_loader_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StCheck,
        StDone,
        StErr
    } state_e;

    state_e           state_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_q;
    logic [7:0]       sum_q;

    logic             in_ready_q;
    logic             wr_en_q;
    logic [LEN_W-1:0] wr_addr_q;
    logic [7:0]       wr_data_q;
    logic             cpu_hold_q;
    logic             busy_q;
    logic             done_q;
    logic             error_q;

    logic             accept;
    logic             last_byte;
    logic             len_too_big;
    logic             len_zero;
    logic [7:0]       sum_next;

    // Handshake and decode helpers shared by the state register below
    always_comb begin
        accept      = bus.in_valid & in_ready_q;
        last_byte   = (cnt_q == (len_q - LEN_W'(1)));
        len_too_big = (bus.len > LEN_W'(MEM_BYTES));
        len_zero    = (bus.len == '0);
        sum_next    = sum_q + bus.in_data;
    end

    // Control FSM with all outputs registered alongside the state
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            len_q      <= '0;
            cnt_q      <= '0;
            sum_q      <= '0;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            cpu_hold_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            // Write strobe is a one-cycle pulse per accepted data byte
            wr_en_q <= 1'b0;

            case (state_q)
                StIdle, StDone, StErr: begin
                    in_ready_q <= 1'b0;
                    if (bus.start) begin
                        len_q      <= bus.len;
                        cnt_q      <= '0;
                        sum_q      <= '0;
                        done_q     <= 1'b0;
                        cpu_hold_q <= 1'b1;
                        if (len_too_big) begin
                            state_q <= StErr;
                            busy_q  <= 1'b0;
                            error_q <= 1'b1;
                        end else begin
                            state_q <= len_zero ? StCheck : StLoad;
                            busy_q  <= 1'b1;
                            error_q <= 1'b0;
                        end
                    end
                end

                StLoad: begin
                    // Ready rises one cycle after entry and stays up until the last byte
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= cnt_q;
                        wr_data_q <= bus.in_data;
                        sum_q     <= sum_next;
                        cnt_q     <= cnt_q + LEN_W'(1);
                        if (last_byte) begin
                            state_q    <= StCheck;
                            in_ready_q <= 1'b0;
                        end
                    end
                end

                StCheck: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        // Checksum byte is consumed but never written to memory
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b0;
                        sum_q      <= sum_next;
                        if (sum_next == 8'h00) begin
                            state_q    <= StDone;
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
                        end else begin
                            state_q <= StErr;
                            error_q <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_q    <= StIdle;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                    error_q    <= 1'b0;
                    cpu_hold_q <= 1'b1;
                end
            endcase
        end
    end

    // Drive the bundle from the registered outputs
    always_comb begin
        bus.in_ready = in_ready_q;
        bus.wr_en    = wr_en_q;
        bus.wr_addr  = {{(64 - LEN_W){1'b0}}, wr_addr_q};
        bus.wr_data  = wr_data_q;
        bus.cpu_hold = cpu_hold_q;
        bus.busy     = busy_q;
        bus.done     = done_q;
        bus.error    = error_q;
    end

    // Structural invariants of the output encoding
    a_ready_busy: assert property (@(posedge clk) disable iff (!reset)
        bus.in_ready |-> bus.busy);
    a_write_busy: assert property (@(posedge clk) disable iff (!reset)
        bus.wr_en |-> bus.busy);
    a_done_release: assert property (@(posedge clk) disable iff (!reset)
        bus.done |-> !bus.cpu_hold);
    a_done_error: assert property (@(posedge clk) disable iff (!reset)
        !(bus.done && bus.error));

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: table of load scenarios plus a reset-mid-load
// sequence. Expected memory writes go into a scoreboard queue when a byte is
// accepted and are matched against the write port one cycle later.
module tb_imem_boot_loader;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;

    imem_boot_loader_if #(.LEN_W(16)) bus ();

    imem_boot_loader #(
        .MEM_BYTES(96),
        .LEN_W    (16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string      name;
        int         len;
        int         kind;
        logic [7:0] cks;
        bit         toggle;
        bit         mid_start;
        bit         do_reset;
        bit         exp_done;
        int         exp_writes;
    } vec_t;

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  data;
        int          due;
    } wr_exp_t;

    wr_exp_t exp_q[$];
    vec_t    vecs[7];
    int      n_checks = 0;
    int      n_pass = 0;
    int      wr_count = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [7:0] data_of(input int kind, input int i);
        case (kind)
            0: case (i)
                   0: return 8'h13;
                   1: return 8'h0B;
                   default: return 8'h00;
               endcase
            1: return 8'(i);
            2: case (i)
                   0: return 8'h37;
                   1: return 8'h81;
                   default: return 8'h49;
               endcase
            default: case (i)
                   0: return 8'h12;
                   default: return 8'h34;
               endcase
        endcase
    endfunction

    // Write-port monitor: every wr_en must match the oldest scoreboard entry
    // and land exactly in its due cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            check("wr_missed", 64'(bus.wr_en), 64'd1);
            void'(exp_q.pop_front());
        end
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            check("wr_en", 64'(bus.wr_en), 64'd1);
            check("wr_addr", bus.wr_addr, exp_q[0].addr);
            check("wr_data", 64'(bus.wr_data), 64'(exp_q[0].data));
            void'(exp_q.pop_front());
        end else if (bus.wr_en) begin
            check("wr_unexpected", 64'(bus.wr_en), 64'd0);
        end
        if (bus.wr_en) wr_count++;
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
        check({tag, "_wr_en"}, 64'(bus.wr_en), 64'd0);
        check({tag, "_wr_addr"}, bus.wr_addr, 64'd0);
        check({tag, "_wr_data"}, 64'(bus.wr_data), 64'd0);
        check({tag, "_cpu_hold"}, 64'(bus.cpu_hold), 64'd1);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_done"}, 64'(bus.done), 64'd0);
        check({tag, "_error"}, 64'(bus.error), 64'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int w0;
        int idx;
        int budget;
        int iter;
        bit ph;
        bit vld;
        bit pulsed;
        bit seen_rdy;
        logic [7:0] b;
        bit over;

        over = (v.len > 96);
        if (v.do_reset) begin
            reset = 1'b0;
            step();
            reset = 1'b1;
        end
        w0 = wr_count;
        check({v.name, "_pre_rdy"}, 64'(bus.in_ready), 64'd0);

        // Start cycle, with a stray valid byte that must not be consumed
        bus.start    = 1'b1;
        bus.len      = 16'(v.len);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        step();
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        check({v.name, "_t1_busy"}, 64'(bus.busy), 64'(!over));
        check({v.name, "_t1_error"}, 64'(bus.error), 64'(over));
        check({v.name, "_t1_hold"}, 64'(bus.cpu_hold), 64'd1);
        check({v.name, "_t1_done"}, 64'(bus.done), 64'd0);
        check({v.name, "_t1_rdy"}, 64'(bus.in_ready), 64'd0);

        if (over) begin
            seen_rdy = 1'b0;
            repeat (5) begin
                bus.in_valid = 1'b1;
                bus.in_data  = 8'h5A;
                step();
                seen_rdy |= bus.in_ready;
            end
            bus.in_valid = 1'b0;
            check({v.name, "_never_rdy"}, 64'(seen_rdy), 64'd0);
            check({v.name, "_writes"}, 64'(wr_count - w0), 64'd0);
            check({v.name, "_error"}, 64'(bus.error), 64'd1);
            return;
        end

        idx    = 0;
        budget = v.len * 3 + 20;
        iter   = 0;
        ph     = 1'b1;
        pulsed = 1'b0;
        while (idx <= v.len && budget > 0) begin
            if (iter == 1) check({v.name, "_t2_rdy"}, 64'(bus.in_ready), 64'd1);
            vld = v.toggle ? ph : 1'b1;
            ph  = ~ph;
            b   = (idx < v.len) ? data_of(v.kind, idx) : v.cks;
            bus.in_valid = vld;
            bus.in_data  = b;
            if (v.mid_start && idx == 1 && !pulsed) begin
                bus.start = 1'b1;
                bus.len   = 16'd5;
                pulsed    = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            if (vld && bus.in_ready) begin
                if (idx < v.len) exp_q.push_back('{64'(idx), b, cyc + 1});
                idx++;
            end
            step();
            iter++;
            budget--;
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;

        check({v.name, "_bytes_taken"}, 64'(idx), 64'(v.len + 1));
        check({v.name, "_done"}, 64'(bus.done), 64'(v.exp_done));
        check({v.name, "_error"}, 64'(bus.error), 64'(!v.exp_done));
        check({v.name, "_hold"}, 64'(bus.cpu_hold), 64'(!v.exp_done));
        check({v.name, "_busy"}, 64'(bus.busy), 64'd0);
        check({v.name, "_rdy"}, 64'(bus.in_ready), 64'd0);
        step();
        check({v.name, "_writes"}, 64'(wr_count - w0), 64'(v.exp_writes));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog timeout");
    end

    initial begin
        vec_t rv;
        int idx;
        int budget;

        vecs[0] = '{"normal", 4, 0, 8'hE2, 1'b0, 1'b0, 1'b1, 1'b1, 4};
        vecs[1] = '{"bad_cks", 4, 0, 8'hE1, 1'b0, 1'b0, 1'b1, 1'b0, 4};
        vecs[2] = '{"len_max", 96, 1, 8'h30, 1'b0, 1'b0, 1'b1, 1'b1, 96};
        vecs[3] = '{"len_over", 97, 1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        vecs[4] = '{"len_zero", 0, 1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 0};
        vecs[5] = '{"backpress", 3, 2, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 3};
        vecs[6] = '{"reload", 2, 3, 8'hBA, 1'b0, 1'b0, 1'b0, 1'b1, 2};

        bus.start    = 1'b0;
        bus.len      = '0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        repeat (2) step();
        check_reset_vals("por");
        reset = 1'b1;
        step();

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Reset in the middle of a load, with a byte offered on the reset edge
        reset = 1'b0;
        step();
        reset = 1'b1;
        bus.start = 1'b1;
        bus.len   = 16'd4;
        step();
        bus.start = 1'b0;
        idx    = 0;
        budget = 20;
        while (idx < 2 && budget > 0) begin
            bus.in_valid = 1'b1;
            bus.in_data  = data_of(0, idx);
            if (bus.in_ready) begin
                exp_q.push_back('{64'(idx), data_of(0, idx), cyc + 1});
                idx++;
            end
            step();
            budget--;
        end
        check("midrst_bytes", 64'(idx), 64'd2);
        reset        = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h00;
        step();
        check_reset_vals("midrst");
        bus.in_valid = 1'b0;
        reset        = 1'b1;

        rv          = vecs[0];
        rv.name     = "restart";
        rv.do_reset = 1'b0;
        run_vec(rv);

        repeat (2) step();
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Boot-time loader for the byte-addressed instruction memory of the single-cycle RISC-V core. Accepts a program as a valid/ready byte stream, writes each byte to the instruction memory write port at consecutive addresses from 0, and verifies a trailing checksum byte. Holds the core stalled until a load completes cleanly. Sits between the host/debug byte link and the instruction memory; the core's PC restarts at address 0 when `cpu_hold` falls.

## Interface
- `MEM_BYTES`, 96: instruction memory size in bytes; the largest legal `len`.
- `LEN_W`, 16: width of `len` and of the internal byte counter.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a load; sampled only in IDLE, DONE and ERR.
- `len`  in  LEN_W  number of program bytes; latched on an accepted `start`.
- `in_valid`  in  1  byte-stream valid.
- `in_data`  in  8  byte-stream data.
- `in_ready`  out  1  byte-stream ready; a byte transfers when `in_valid & in_ready`.
- `wr_en`  out  1  instruction memory byte-write strobe.
- `wr_addr`  out  64  byte address, zero-extended; matches the memory's 64-bit address.
- `wr_data`  out  8  byte to write.
- `cpu_hold`  out  1  high keeps the core stalled with PC at 0.
- `busy`  out  1  high in LOAD and CHECK.
- `done`  out  1  high in DONE.
- `error`  out  1  high in ERR.

## Operation
- States: IDLE, LOAD, CHECK, DONE, ERR.
- IDLE: on `start`, latch `len`, clear the byte counter `cnt` and the running sum `sum`.
  - `len > MEM_BYTES` → ERR.
  - `len == 0` → CHECK.
  - Otherwise → LOAD.
- LOAD: each accepted byte is written at address `cnt`; `sum <= sum + in_data` (mod 256); `cnt` increments.
  - Acceptance of byte number `len-1` (`cnt == len-1`) → CHECK.
- CHECK: accept exactly one checksum byte `c`.
  - `(sum + c) mod 256 == 0` → DONE, else → ERR.
  - The checksum byte is never written to memory.
- DONE: `cpu_hold=0`, `done=1`. On `start` → same entry rules as IDLE, and `cpu_hold` rises again.
- ERR: `cpu_hold=1`, `error=1`. On `start` → same entry rules as IDLE.
- `start` in LOAD/CHECK is ignored.
- `in_valid` outside LOAD/CHECK is ignored: `in_ready` is 0 and no write occurs.
- Memory contents are never cleared by this block. A failed or aborted load leaves partially written bytes; `cpu_hold` protects the core from them.

## Timing
- Reset values:
  - `in_ready=0`, `wr_en=0`, `wr_addr=0`, `wr_data=0`
  - `cpu_hold=1`, `busy=0`, `done=0`, `error=0`
  - state IDLE, `cnt=0`, `sum=0`
- All outputs are registered.
- `in_ready` is 1 exactly in LOAD and CHECK, from the cycle after the state is entered.
- It is 0 in the cycle after the final byte of the current state is accepted.
  - At most one byte is accepted per cycle.
  - Back-to-back acceptance at 1 byte/cycle is required.
- Write latency is 1: a byte accepted in cycle t gives `wr_en=1`, `wr_addr=cnt`, `wr_data=byte` in cycle t+1.
  - `wr_en` is 0 in any cycle without a preceding acceptance.
- The final data byte's write (cycle t+1) coincides with the first CHECK cycle. It must complete regardless of the state change.
- Flags follow the state with 1-cycle latency:
  - `start` accepted at t → `busy=1` at t+1 (or `error=1` at t+1 when `len > MEM_BYTES`).
  - Checksum byte accepted at t → `done=1`, `cpu_hold=0` at t+1 (or `error=1`).
- `start` accepted in DONE: `done=0`, `cpu_hold=1`, `busy=1` at t+1.
- `in_valid` asserted in the same cycle `start` is accepted is not consumed; `in_ready` is still 0 then.
- `reset` low in any state (including mid-LOAD) returns every output to its reset value on the next edge. An in-flight `wr_en` is dropped.
- Counter width: `cnt` counts to `MEM_BYTES-1`. `wr_addr` is `cnt` zero-extended to 64 bits. No wrap is possible because `len ≤ MEM_BYTES` is enforced.

## Test plan
- Normal load: reset, `start` with `len=4`, stream 0x13,0x0B,0x00,0x00, then checksum 0xE2, `in_valid` held high.
  - Writes at addresses 0..3 with those bytes on 4 consecutive cycles.
  - `done=1`, `cpu_hold=0` one cycle after 0xE2 is accepted.
- Bad checksum: same stream with checksum 0xE1.
  - 4 writes occur; `error=1`, `cpu_hold=1`, `done=0`.
- Boundaries:
  - `len=96` with bytes 0..95 and checksum 0x30 → 96 writes, last at `wr_addr=95`, then DONE.
  - `len=97` → ERR the cycle after `start`, with no writes and `in_ready` never 1.
  - `len=0` with checksum 0x00 → DONE with zero writes.
- Backpressure and ignored inputs, with `len=3`:
  - `in_valid` toggled 1,0,1,0,1 → exactly 3 writes, each one cycle after its acceptance.
  - `start` pulsed mid-LOAD has no effect.
- Reset mid-load: drop `reset` after 2 of 4 bytes.
  - All outputs at reset values next cycle, `cpu_hold=1`.
  - A fresh `start` with `len=4` restarts writes at address 0.
- Reload from DONE: after a successful load, `start` with `len=2`.
  - `cpu_hold` rises the next cycle; `busy=1`; `done` returns to 1 after a valid checksum.
